pc_step_ctrl: RTL and testbench

Multi-cycle instruction sequencer that owns the architectural program counter and steps each instruction through fetch, decode, execute, memory and write-back phases. It drives the PC register's `coming_pc` input with a held, registered value, so the PC register may load unconditionally every clock. It also emits the per-phase strobes (instruction-register load, memory read/write, register-file write) that the rest of the datapath uses.

---
 rtl/pc_step_ctrl.sv | 132 +++++++++++++
 tb/tb_pc_step_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_step_ctrl.sv
// Multi-cycle instruction sequencer: owns the architectural PC and walks each
// instruction through IF/ID/EX/MEM/WB, emitting per-phase datapath strobes.
module pc_step_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [2:0]  instr_class,
   input  logic        branch_cond,
   input  logic [15:0] branch_offset,
   input  logic [25:0] jump_index,
   input  logic [31:0] jr_target,
   input  logic        mem_ready,
   output logic [31:0] pc_next,
   output logic        pc_we,
   output logic [2:0]  phase,
   output logic        ir_we,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic        reg_we,
   output logic        halted,
   output logic        illegal
);

   typedef enum logic [2:0] {
      S_IF     = 3'd0,
      S_ID     = 3'd1,
      S_EX     = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALTED = 3'd5
   } state_t;

   localparam logic [2:0] C_ALU    = 3'd0;
   localparam logic [2:0] C_LOAD   = 3'd1;
   localparam logic [2:0] C_STORE  = 3'd2;
   localparam logic [2:0] C_BRANCH = 3'd3;
   localparam logic [2:0] C_JUMP   = 3'd4;
   localparam logic [2:0] C_JR     = 3'd5;
   localparam logic [2:0] C_HALT   = 3'd6;

   state_t      state_q, state_d;
   logic [2:0]  cls_q, cls_d;
   logic [31:0] pc_q, pc_d;
   logic        illegal_q, illegal_d;

   logic [31:0] seq;
   logic [31:0] br_off;
   logic [31:0] target;
   logic        commit;
   logic        is_ctrl;

   always_comb begin
      seq     = pc_q + PC_STEP;
      br_off  = {{14{branch_offset[15]}}, branch_offset, 2'b00};
      is_ctrl = (cls_q == C_BRANCH) || (cls_q == C_JUMP) || (cls_q == C_JR);

      target = seq;
      case (cls_q)
         C_BRANCH: target = branch_cond ? (seq + br_off) : seq;
         C_JUMP:   target = {seq[31:28], jump_index, 2'b00};
         C_JR:     target = jr_target;
         default:  target = seq;
      endcase

      // The commit cycle is the last cycle of every non-halting instruction.
      commit = ((state_q == S_EX) && is_ctrl) ||
               ((state_q == S_MEM) && mem_ready && (cls_q == C_STORE)) ||
               (state_q == S_WB);

      state_d   = state_q;
      cls_d     = cls_q;
      illegal_d = illegal_q;
      pc_d      = commit ? target : pc_q;

      case (state_q)
         S_IF: state_d = S_ID;
         S_ID: begin
            state_d = S_EX;
            cls_d   = instr_class;
         end
         S_EX: begin
            case (cls_q)
               C_ALU:                state_d = S_WB;
               C_LOAD, C_STORE:      state_d = S_MEM;
               C_BRANCH, C_JUMP,
               C_JR:                 state_d = S_IF;
               C_HALT:               state_d = S_HALTED;
               default: begin
                  state_d   = S_HALTED;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_MEM: begin
            if (mem_ready) begin
               state_d = (cls_q == C_LOAD) ? S_WB : S_IF;
            end
         end
         S_WB:     state_d = S_IF;
         S_HALTED: state_d = S_HALTED;
         default:  state_d = S_IF;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= S_IF;
         cls_q     <= 3'd0;
         pc_q      <= RESET_PC;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cls_q     <= cls_d;
         pc_q      <= pc_d;
         illegal_q <= illegal_d;
      end
   end

   // Strobes are pure state decodes, suppressed while reset is held.
   assign pc_next = pc_q;
   assign phase   = RESET ? 3'd0 : state_q;
   assign pc_we   = ~RESET & commit;
   assign ir_we   = ~RESET & (state_q == S_IF);
   assign mem_rd  = ~RESET & (state_q == S_MEM) & (cls_q == C_LOAD);
   assign mem_wr  = ~RESET & (state_q == S_MEM) & (cls_q == C_STORE);
   assign reg_we  = ~RESET & (state_q == S_WB);
   assign halted  = ~RESET & (state_q == S_HALTED);
   assign illegal = illegal_q;

endmodule

// File: tb/tb_pc_step_ctrl.sv
// Bench for pc_step_ctrl: directed scenarios plus a random instruction stream,
// each instruction checked cycle by cycle against an instruction-level model.
module tb_pc_step_ctrl;

  logic        clk = 1'b0;
  logic        RESET;
  logic [2:0]  instr_class;
  logic        branch_cond;
  logic [15:0] branch_offset;
  logic [25:0] jump_index;
  logic [31:0] jr_target;
  logic        mem_ready;
  logic [31:0] pc_next;
  logic        pc_we;
  logic [2:0]  phase;
  logic        ir_we;
  logic        mem_rd;
  logic        mem_wr;
  logic        reg_we;
  logic        halted;
  logic        illegal;

  int          n_checks = 0;
  int          n_err = 0;
  logic [31:0] pc_model;
  logic        ill_model;

  pc_step_ctrl dut (
    .CLK           (clk),
    .RESET         (RESET),
    .instr_class   (instr_class),
    .branch_cond   (branch_cond),
    .branch_offset (branch_offset),
    .jump_index    (jump_index),
    .jr_target     (jr_target),
    .mem_ready     (mem_ready),
    .pc_next       (pc_next),
    .pc_we         (pc_we),
    .phase         (phase),
    .ir_we         (ir_we),
    .mem_rd        (mem_rd),
    .mem_wr        (mem_wr),
    .reg_we        (reg_we),
    .halted        (halted),
    .illegal       (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered 1 time unit after a rising edge; leaves at the same point of the
  // first cycle with RESET low.
  task automatic do_reset();
    RESET = 1'b1;
    #4;
    chk("rst_phase",  32'(phase),  32'd0);
    chk("rst_pc_we",  32'(pc_we),  32'd0);
    chk("rst_ir_we",  32'(ir_we),  32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_reg_we", 32'(reg_we), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    @(posedge clk);
    #1;
    RESET     = 1'b0;
    pc_model  = 32'h0000_0000;
    ill_model = 1'b0;
  endtask

  // One instruction: the model lists the phases it should visit and the PC
  // it should commit; abort >= 0 asserts RESET at that cycle index instead.
  task automatic run_instr(input logic [2:0] cls, input logic cond, input logic [15:0] off,
                           input logic [25:0] jidx, input logic [31:0] jr,
                           input int waits, input int abort);
    int          ph[$];
    int          mem_i;
    logic [31:0] seq;
    logic [31:0] tgt;
    logic        commits;

    seq = pc_model + 32'd4;
    case (cls)
      3'd3:    tgt = cond ? seq + 32'($signed(off) * 4) : seq;
      3'd4:    tgt = (seq & 32'hF000_0000) | ({6'd0, jidx} * 32'd4);
      3'd5:    tgt = jr;
      default: tgt = seq;
    endcase
    commits = (cls <= 3'd5);

    ph = '{0, 1, 2};
    if (cls == 3'd1 || cls == 3'd2)
      for (int k = 0; k <= waits; k++) ph.push_back(3);
    if (cls == 3'd0 || cls == 3'd1) ph.push_back(4);
    if (!commits)
      for (int k = 0; k < 10; k++) ph.push_back(5);

    branch_cond   = cond;
    branch_offset = off;
    jump_index    = jidx;
    jr_target     = jr;
    mem_i         = 0;

    for (int i = 0; i < ph.size(); i++) begin
      instr_class = (ph[i] == 1 || ph[i] == 2) ? cls : 3'($urandom);
      if (ph[i] == 3) begin
        mem_ready = (mem_i == waits);
        mem_i++;
      end else begin
        mem_ready = 1'($urandom);
      end
      if (i == abort) begin
        do_reset();
        return;
      end
      if (ph[i] == 5 && cls == 3'd7) ill_model = 1'b1;
      #4;
      chk("phase",   32'(phase),   32'(ph[i]));
      chk("ir_we",   32'(ir_we),   32'(ph[i] == 0));
      chk("mem_rd",  32'(mem_rd),  32'(ph[i] == 3 && cls == 3'd1));
      chk("mem_wr",  32'(mem_wr),  32'(ph[i] == 3 && cls == 3'd2));
      chk("reg_we",  32'(reg_we),  32'(ph[i] == 4));
      chk("halted",  32'(halted),  32'(ph[i] == 5));
      chk("illegal", 32'(illegal), 32'(ill_model));
      chk("pc_we",   32'(pc_we),   32'(commits && i == ph.size() - 1));
      chk("pc_next", pc_next,      pc_model);
      @(posedge clk);
      #1;
    end
    if (commits) pc_model = tgt;
  endtask

  initial begin
    RESET         = 1'b1;
    instr_class   = 3'd0;
    branch_cond   = 1'b0;
    branch_offset = 16'd0;
    jump_index    = 26'd0;
    jr_target     = 32'd0;
    mem_ready     = 1'b0;
    pc_model      = 32'd0;
    ill_model     = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // three ALU instructions from reset: 0 -> 4 -> 8 -> C
    run_instr(3'd0, 1'b0, 16'd0, 26'd0, 32'd0, 0, -1);
    run_instr(3'd0, 1'b0, 16'd0, 26'd0, 32'd0, 0, -1);
    run_instr(3'd0, 1'b0, 16'd0, 26'd0, 32'd0, 0, -1);
    chk("alu_stream_pc", pc_next, 32'h0000_000C);

    // branches at 0x100
    run_instr(3'd5, 1'b0, 16'd0, 26'd0, 32'h0000_0100, 0, -1);
    run_instr(3'd3, 1'b1, 16'hFFFE, 26'd0, 32'd0, 0, -1);
    chk("branch_taken_pc", pc_next, 32'h0000_00FC);
    run_instr(3'd5, 1'b0, 16'd0, 26'd0, 32'h0000_0100, 0, -1);
    run_instr(3'd3, 1'b0, 16'hFFFE, 26'd0, 32'd0, 0, -1);
    chk("branch_not_taken_pc", pc_next, 32'h0000_0104);

    // jumps
    run_instr(3'd5, 1'b0, 16'd0, 26'd0, 32'h3000_0010, 0, -1);
    run_instr(3'd4, 1'b0, 16'd0, 26'h0000040, 32'd0, 0, -1);
    chk("jump_pc", pc_next, 32'h3000_0100);
    run_instr(3'd5, 1'b0, 16'd0, 26'd0, 32'h1234_5678, 0, -1);
    chk("jr_pc", pc_next, 32'h1234_5678);

    // LOAD with two wait cycles
    run_instr(3'd1, 1'b0, 16'd0, 26'd0, 32'd0, 2, -1);
    chk("load_pc", pc_next, 32'h1234_567C);

    // wrap-around
    run_instr(3'd5, 1'b0, 16'd0, 26'd0, 32'hFFFF_FFFC, 0, -1);
    run_instr(3'd0, 1'b0, 16'd0, 26'd0, 32'd0, 0, -1);
    chk("wrap_pc", pc_next, 32'h0000_0000);

    // reset during a STORE wait cycle, then a clean instruction from IF
    run_instr(3'd5, 1'b0, 16'd0, 26'd0, 32'h0000_0200, 0, -1);
    run_instr(3'd2, 1'b0, 16'd0, 26'd0, 32'd0, 3, 4);
    run_instr(3'd0, 1'b0, 16'd0, 26'd0, 32'd0, 0, -1);

    // HALT, then reset; illegal, then reset
    run_instr(3'd0, 1'b0, 16'd0, 26'd0, 32'd0, 0, -1);
    run_instr(3'd6, 1'b0, 16'd0, 26'd0, 32'd0, 0, -1);
    do_reset();
    run_instr(3'd7, 1'b0, 16'd0, 26'd0, 32'd0, 0, -1);
    do_reset();
    chk("post_reset_pc", pc_next, 32'h0000_0000);
    chk("post_reset_illegal", 32'(illegal), 32'd0);

    // random instruction stream
    for (int n = 0; n < 60; n++) begin
      run_instr(3'($urandom_range(0, 5)), 1'($urandom), 16'($urandom), 26'($urandom),
                $urandom, $urandom_range(0, 3), -1);
    end
    chk("random_final_pc", pc_next, pc_model);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
